// File: rtl/ahb_master_arbiter.sv
// Round-robin AHB bus arbiter; holds the grant for fixed-length and capped INCR bursts.
// Grant and owner are registered (one edge); they change only on Hreadyout=1 edges; masters wait on req.
module ahb_master_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int HOLD_MAX    = 16,
  parameter int MW          = $clog2(NUM_MASTERS)
) (
  input  logic                   clock,
  input  logic                   Hreset,
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [1:0]             Htrans,
  input  logic [2:0]             Hburst,
  input  logic                   Hreadyout,
  input  logic [1:0]             Hresp,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [MW-1:0]          Hmaster,
  output logic [MW-1:0]          Hmaster_data
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;
  localparam logic [2:0] HB_INCR   = 3'b001;
  localparam logic [1:0] RESP_ERR  = 2'b01;

  typedef enum logic [1:0] {ARB, BURST, HOLD} state_t;

  state_t                 state, state_nxt;
  logic [4:0]             cnt, cnt_nxt, cnt_inc, burst_len_m1;
  logic                   accepted, is_err, fixed_burst, rearb;
  logic                   rr_found;
  logic [MW-1:0]          rr_master, cand, master_nxt;
  logic [NUM_MASTERS-1:0] grant_nxt;

  assign accepted    = Hreadyout && Htrans[1];
  assign is_err      = (Hresp == RESP_ERR);
  assign fixed_burst = (Hburst[2:1] != 2'b00);
  assign cnt_inc     = cnt + 5'd1;

  always_comb begin
    case (Hburst)
      3'b010, 3'b011: burst_len_m1 = 5'd3;
      3'b100, 3'b101: burst_len_m1 = 5'd7;
      3'b110, 3'b111: burst_len_m1 = 5'd15;
      default:        burst_len_m1 = 5'd0;
    endcase
  end

  // Search starts just after the owner and wraps, so the owner is considered last.
  always_comb begin
    rr_found  = 1'b0;
    rr_master = Hmaster;
    cand      = Hmaster;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      cand = (int'(cand) == NUM_MASTERS - 1) ? '0 : cand + 1'b1;
      if (!rr_found && req[cand]) begin
        rr_found  = 1'b1;
        rr_master = cand;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rearb     = 1'b0;
    case (state)
      ARB: begin
        if (Hreadyout) begin
          if (Htrans == TR_NONSEQ && fixed_burst) begin
            state_nxt = BURST;
            cnt_nxt   = burst_len_m1;
          end else if (Htrans == TR_NONSEQ && Hburst == HB_INCR && req[Hmaster]) begin
            state_nxt = HOLD;
            cnt_nxt   = 5'd1;
          end else begin
            rearb = 1'b1;
          end
        end
      end
      BURST: begin
        // An error response abandons the burst but keeps the owner until the next ready edge.
        if (is_err) begin
          state_nxt = ARB;
          cnt_nxt   = 5'd0;
        end else if (Hreadyout) begin
          if (Htrans == TR_SEQ) begin
            if (cnt <= 5'd1) begin
              rearb     = 1'b1;
              state_nxt = ARB;
              cnt_nxt   = 5'd0;
            end else begin
              cnt_nxt = cnt - 5'd1;
            end
          end else if (Htrans == TR_IDLE) begin
            rearb     = 1'b1;
            state_nxt = ARB;
            cnt_nxt   = 5'd0;
          end
        end
      end
      HOLD: begin
        if (is_err) begin
          state_nxt = ARB;
          cnt_nxt   = 5'd0;
        end else if (Hreadyout) begin
          // cnt_inc is the number of beats held including the one accepted now.
          if (!req[Hmaster] || Htrans == TR_IDLE ||
              (accepted && int'(cnt_inc) >= HOLD_MAX)) begin
            rearb     = 1'b1;
            state_nxt = ARB;
            cnt_nxt   = 5'd0;
          end else if (accepted) begin
            cnt_nxt = cnt_inc;
          end
        end
      end
      default: begin
        state_nxt = ARB;
        cnt_nxt   = 5'd0;
      end
    endcase
  end

  always_comb begin
    master_nxt            = (rearb && rr_found) ? rr_master : Hmaster;
    grant_nxt             = '0;
    grant_nxt[master_nxt] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (Hreset) begin
      state        <= ARB;
      cnt          <= 5'd0;
      Hmaster      <= '0;
      grant        <= {{(NUM_MASTERS-1){1'b0}}, 1'b1};
      Hmaster_data <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      Hmaster <= master_nxt;
      grant   <= grant_nxt;
      if (Hreadyout) Hmaster_data <= Hmaster;
    end
  end

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed bench for ahb_master_arbiter with hand-computed grant/owner expectations.
module tb_ahb_master_arbiter;

  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11;
  localparam logic [2:0] SINGLE = 3'b000, INCR = 3'b001, INCR4 = 3'b011,
                         INCR8 = 3'b101, INCR16 = 3'b111;
  localparam logic [1:0] OKAY = 2'b00, ERROR = 2'b01;

  logic       clock = 1'b0;
  logic       Hreset;
  logic [3:0] req;
  logic [1:0] Htrans;
  logic [2:0] Hburst;
  logic       Hreadyout;
  logic [1:0] Hresp;
  logic [3:0] grant;
  logic [1:0] Hmaster;
  logic [1:0] Hmaster_data;

  int checks   = 0;
  int failures = 0;

  ahb_master_arbiter #(.NUM_MASTERS(4), .HOLD_MAX(16)) dut (
    .clock       (clock),
    .Hreset      (Hreset),
    .req         (req),
    .Htrans      (Htrans),
    .Hburst      (Hburst),
    .Hreadyout   (Hreadyout),
    .Hresp       (Hresp),
    .grant       (grant),
    .Hmaster     (Hmaster),
    .Hmaster_data(Hmaster_data)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [3:0] r, input logic [1:0] t, input logic [2:0] b,
                       input logic rdy, input logic [1:0] rs);
    req       = r;
    Htrans    = t;
    Hburst    = b;
    Hreadyout = rdy;
    Hresp     = rs;
  endtask

  task automatic park_to(input int m);
    logic [3:0] v;
    v = 4'b0001 << m;
    drive(v, IDLE, SINGLE, 1'b1, OKAY);
    tick();
  endtask

  task automatic test_reset();
    Hreset = 1'b1;
    drive(4'b0000, IDLE, SINGLE, 1'b1, OKAY);
    tick();
    tick();
    checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL reset_grant got=%b exp=0001", grant); end
    checks++; if (Hmaster !== 2'd0) begin failures++; $display("FAIL reset_hmaster got=%0d exp=0", Hmaster); end
    checks++; if (Hmaster_data !== 2'd0) begin failures++; $display("FAIL reset_hmaster_data got=%0d exp=0", Hmaster_data); end
    checks++; if (dut.cnt !== 5'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", dut.cnt); end
    Hreset = 1'b0;
    tick();
    checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL idle_park got=%b exp=0001", grant); end
    drive(4'b0100, IDLE, SINGLE, 1'b1, OKAY);
    tick();
    checks++; if (grant !== 4'b0100) begin failures++; $display("FAIL park_to_2 got=%b exp=0100", grant); end
    checks++; if (Hmaster_data !== 2'd0) begin failures++; $display("FAIL park_data_lag got=%0d exp=0", Hmaster_data); end
    tick();
    checks++; if (Hmaster_data !== 2'd2) begin failures++; $display("FAIL park_data_follow got=%0d exp=2", Hmaster_data); end
  endtask

  task automatic test_incr4();
    park_to(1);
    drive(4'b1111, NONSEQ, INCR4, 1'b1, OKAY);
    tick();
    checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL incr4_beat1 got=%b exp=0010", grant); end
    drive(4'b1111, SEQ, INCR4, 1'b0, OKAY);
    tick();
    checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL incr4_wait got=%b exp=0010", grant); end
    checks++; if (Hmaster_data !== 2'd1) begin failures++; $display("FAIL incr4_wait_data got=%0d exp=1", Hmaster_data); end
    for (int b = 2; b <= 4; b++) begin
      logic [3:0] exp_g;
      exp_g = (b < 4) ? 4'b0010 : 4'b0100;
      drive(4'b1111, SEQ, INCR4, 1'b1, OKAY);
      tick();
      checks++; if (grant !== exp_g) begin failures++; $display("FAIL incr4_beat%0d got=%b exp=%b", b, grant, exp_g); end
    end
    checks++; if (Hmaster_data !== 2'd1) begin failures++; $display("FAIL incr4_last_data got=%0d exp=1", Hmaster_data); end
    drive(4'b1111, IDLE, SINGLE, 1'b1, OKAY);
    tick();
    checks++; if (Hmaster_data !== 2'd2) begin failures++; $display("FAIL incr4_next_data got=%0d exp=2", Hmaster_data); end
    checks++; if (grant !== 4'b1000) begin failures++; $display("FAIL incr4_next_grant got=%b exp=1000", grant); end
  endtask

  task automatic test_round_robin();
    park_to(0);
    drive(4'b1111, NONSEQ, SINGLE, 1'b1, OKAY);
    for (int i = 1; i <= 8; i++) begin
      logic [1:0] exp_m;
      logic [3:0] exp_g;
      exp_m = 2'(i % 4);
      exp_g = 4'b0001 << exp_m;
      tick();
      checks++; if (Hmaster !== exp_m || grant !== exp_g) begin
        failures++; $display("FAIL rr_step%0d got=%0d/%b exp=%0d/%b", i, Hmaster, grant, exp_m, exp_g);
      end
    end
    drive(4'b1111, NONSEQ, SINGLE, 1'b0, OKAY);
    tick();
    checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL rr_wait_hold got=%b exp=0001", grant); end
  endtask

  task automatic test_incr_hold();
    park_to(2);
    drive(4'b1111, NONSEQ, INCR, 1'b1, OKAY);
    tick();
    checks++; if (grant !== 4'b0100) begin failures++; $display("FAIL hold_beat1 got=%b exp=0100", grant); end
    for (int b = 2; b <= 16; b++) begin
      logic [3:0] exp_g;
      if (b == 9) begin
        drive(4'b1111, BUSY, INCR, 1'b1, OKAY);
        tick();
      end
      exp_g = (b < 16) ? 4'b0100 : 4'b1000;
      drive(4'b1111, SEQ, INCR, 1'b1, OKAY);
      tick();
      checks++; if (grant !== exp_g) begin failures++; $display("FAIL hold_beat%0d got=%b exp=%b", b, grant, exp_g); end
    end
    park_to(2);
    drive(4'b0111, NONSEQ, INCR, 1'b1, OKAY);
    tick();
    for (int b = 2; b <= 4; b++) begin
      drive(4'b0111, SEQ, INCR, 1'b1, OKAY);
      tick();
    end
    checks++; if (grant !== 4'b0100) begin failures++; $display("FAIL drop_beat4 got=%b exp=0100", grant); end
    drive(4'b0011, SEQ, INCR, 1'b1, OKAY);
    tick();
    checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL drop_beat5 got=%b exp=0001", grant); end
  endtask

  task automatic test_error();
    park_to(0);
    drive(4'b0011, NONSEQ, INCR8, 1'b1, OKAY);
    tick();
    drive(4'b0011, SEQ, INCR8, 1'b1, OKAY);
    tick();
    tick();
    checks++; if (dut.cnt !== 5'd5) begin failures++; $display("FAIL err_cnt_before got=%0d exp=5", dut.cnt); end
    drive(4'b0011, SEQ, INCR8, 1'b0, ERROR);
    tick();
    checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL err_first_cycle got=%b exp=0001", grant); end
    checks++; if (dut.cnt !== 5'd0) begin failures++; $display("FAIL err_cnt_clear got=%0d exp=0", dut.cnt); end
    drive(4'b0011, IDLE, SINGLE, 1'b1, ERROR);
    tick();
    checks++; if (grant !== 4'b0010 || Hmaster !== 2'd1) begin
      failures++; $display("FAIL err_rearb got=%b/%0d exp=0010/1", grant, Hmaster);
    end
  endtask

  task automatic test_reset_mid_burst();
    park_to(3);
    drive(4'b1001, NONSEQ, INCR16, 1'b1, OKAY);
    tick();
    checks++; if (dut.cnt !== 5'd15) begin failures++; $display("FAIL rst_burst_cnt got=%0d exp=15", dut.cnt); end
    Hreset = 1'b1;
    drive(4'b1001, SEQ, INCR16, 1'b1, OKAY);
    tick();
    Hreset = 1'b0;
    checks++; if (grant !== 4'b0001 || Hmaster !== 2'd0 || Hmaster_data !== 2'd0) begin
      failures++; $display("FAIL rst_mid_outputs got=%b/%0d/%0d exp=0001/0/0", grant, Hmaster, Hmaster_data);
    end
    checks++; if (dut.cnt !== 5'd0) begin failures++; $display("FAIL rst_mid_cnt got=%0d exp=0", dut.cnt); end
    drive(4'b0001, SEQ, INCR16, 1'b1, OKAY);
    tick();
    checks++; if (grant !== 4'b0001 || dut.cnt !== 5'd0) begin
      failures++; $display("FAIL rst_no_resume got=%b/%0d exp=0001/0", grant, dut.cnt);
    end
  endtask

  initial begin
    Hreset = 1'b1;
    drive(4'b0000, IDLE, SINGLE, 1'b1, OKAY);
    test_reset();
    test_incr4();
    test_round_robin();
    test_incr_hold();
    test_error();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
